// File: rtl/seq_mult8.sv
// Sequential unsigned 8x8 shift-and-add multiplier. One ripple-carry adder is
// reused for eight iterations to build a 16-bit product in {ACC, Q}.

module full_adder8b (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  logic [8:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
  end

  assign cout = c[8];
endmodule

module seq_mult8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] P,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [7:0]  m_q, m_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  q_q, q_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] p_q, p_d;

  logic [7:0]  add_b;
  logic [7:0]  sum;
  logic        cout;

  assign add_b = q_q[0] ? m_q : 8'h00;

  full_adder8b u_add (
    .a    (acc_q),
    .b    (add_b),
    .cin  (1'b0),
    .s    (sum),
    .cout (cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= 8'h00;
      acc_q   <= 8'h00;
      q_q     <= 8'h00;
      cnt_q   <= 3'd0;
      p_q     <= 16'h0000;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
    end
  end

  // Next state plus datapath. In RUN the 9-bit sum and Q shift right as one
  // unit, so the adder carry lands in ACC[7] and is never lost.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d     = A;
          q_d     = B;
          acc_d   = 8'h00;
          cnt_d   = 3'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = {cout, sum[7:1]};
        q_d   = {sum[0], q_q[7:1]};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          p_d     = {cout, sum, q_q[7:1]};
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign P = p_q;
endmodule
